// File: rtl/iob_arbiter_rsp_demux.sv
// ----------------------------------------------------------------------------
// iob_arbiter_rsp_demux
//
// Return-path companion to the arbiter's priority encoder. Each issued request
// pushes its binary grant index into an in-order tag FIFO. The FIFO head is
// decoded to one-hot and used to steer each returning downstream response to
// the requester that issued it.
//
// Ports:
//   clk_i          clock
//   cke_i          clock enable; when low all state holds, no handshake
//   arst_i         asynchronous active-high reset
//   req_valid_i    request issued downstream this cycle
//   req_sel_i      binary grant index of the issued request
//   req_ready_o    tag FIFO can accept a new tag (not full)
//   rsp_valid_i    downstream response valid
//   rsp_data_i     downstream response data
//   rsp_ready_o    downstream response accepted
//   rsp_valid_o    per-requester response valid (N bits)
//   rsp_data_o     per-requester data, slice i = [i*DATA_W +: DATA_W]
//   rsp_ready_i    per-requester ready (N bits)
//   rsp_sel_o      one-hot decode of the FIFO head, zero when empty
//   outstanding_o  tag FIFO occupancy
//   err_o          sticky error: response with no tag, or out-of-range tag
//
// Optional feature macro: IOB_ARBITER_RSP_DEMUX_OUT_REG_EN
//   When defined, a one-entry output register stage follows the routing
//   logic, adding one cycle of response latency at full throughput.
// ----------------------------------------------------------------------------
module iob_arbiter_rsp_demux #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = $clog2(N),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic                req_valid_i,
    input  logic [SEL_W-1:0]    req_sel_i,
    output logic                req_ready_o,
    input  logic                rsp_valid_i,
    input  logic [DATA_W-1:0]   rsp_data_i,
    output logic                rsp_ready_o,
    output logic [N-1:0]        rsp_valid_o,
    output logic [N*DATA_W-1:0] rsp_data_o,
    input  logic [N-1:0]        rsp_ready_i,
    output logic [N-1:0]        rsp_sel_o,
    output logic [CNT_W-1:0]    outstanding_o,
    output logic                err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [SEL_W-1:0] tagMem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             errSet;
    logic [SEL_W-1:0] headTag;
    logic [N-1:0]     headOneHot;
    logic             headOk;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign headTag = tagMem_q[rdPtr_q];

    // A head tag that matches no port (only possible when N is not a power
    // of two) decodes to all-zero, which is how headOk detects it.
    always_comb begin
        headOneHot = '0;
        for (int i = 0; i < N; i++) begin
            headOneHot[i] = (headTag == SEL_W'(i));
        end
    end

    assign headOk = |headOneHot;

    // No full-bypass: a push is refused whenever the FIFO is full, even if a
    // pop happens in the same cycle.
    assign req_ready_o   = !full;
    assign push          = req_valid_i && req_ready_o && cke_i;
    assign pop           = rsp_valid_i && rsp_ready_o && cke_i;
    assign errSet        = rsp_valid_i && (empty || !headOk);
    assign outstanding_o = count_q;
    assign err_o         = err_q;

`ifdef IOB_ARBITER_RSP_DEMUX_OUT_REG_EN
    logic              stageValid_q;
    logic [DATA_W-1:0] stageData_q;
    logic [N-1:0]      stageSel_q;
    logic              stageDrain;

    assign stageDrain  = stageValid_q && |(stageSel_q & rsp_ready_i);
    assign rsp_ready_o = !empty && (!stageValid_q || stageDrain);

    // One-entry output stage. A pop loads it; a bad head tag loads an invalid
    // entry so the response is dropped. Otherwise it empties once drained.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            stageValid_q <= 1'b0;
            stageData_q  <= '0;
            stageSel_q   <= '0;
        end else if (cke_i) begin
            if (pop) begin
                stageValid_q <= headOk;
                stageData_q  <= rsp_data_i;
                stageSel_q   <= headOneHot;
            end else if (stageDrain) begin
                stageValid_q <= 1'b0;
                stageSel_q   <= '0;
            end
        end
    end

    assign rsp_valid_o = stageValid_q ? stageSel_q : '0;
    assign rsp_data_o  = {N{stageData_q}};
    assign rsp_sel_o   = stageSel_q;
`else
    logic headReady;

    assign headReady = |(headOneHot & rsp_ready_i);

    // A bad head tag is always accepted so the response drains and is dropped.
    assign rsp_ready_o = !empty && (headOk ? headReady : 1'b1);
    assign rsp_valid_o = (!empty && rsp_valid_i) ? headOneHot : '0;
    assign rsp_data_o  = {N{rsp_data_i}};
    assign rsp_sel_o   = empty ? '0 : headOneHot;
`endif

    // Tag storage needs no reset: entries are only read once the count says
    // they were written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tagMem_q[wrPtr_q] <= req_sel_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // holds on a simultaneous push and pop.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (errSet) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_arbiter_rsp_demux.sv
// Self-checking bench for iob_arbiter_rsp_demux (default build, N=4, DEPTH=4).
// A queue-based model predicts every output each cycle; directed sequences
// add literal expectations that pin the model, then random traffic follows.
module tb_iob_arbiter_rsp_demux;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic          clk = 1'b0;
    logic          cke;
    logic          arst;
    logic          reqValid;
    logic [1:0]    reqSel;
    logic          reqReady;
    logic          rspValidIn;
    logic [31:0]   rspDataIn;
    logic          rspReadyOut;
    logic [3:0]    rspValidOut;
    logic [127:0]  rspDataOut;
    logic [3:0]    rspReadyIn;
    logic [3:0]    rspSel;
    logic [2:0]    outstanding;
    logic          err;

    int total = 0;
    int bad   = 0;

    int mq[$];
    bit mErr = 1'b0;

    iob_arbiter_rsp_demux #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .cke_i        (cke),
        .arst_i       (arst),
        .req_valid_i  (reqValid),
        .req_sel_i    (reqSel),
        .req_ready_o  (reqReady),
        .rsp_valid_i  (rspValidIn),
        .rsp_data_i   (rspDataIn),
        .rsp_ready_o  (rspReadyOut),
        .rsp_valid_o  (rspValidOut),
        .rsp_data_o   (rspDataOut),
        .rsp_ready_i  (rspReadyIn),
        .rsp_sel_o    (rspSel),
        .outstanding_o(outstanding),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Inputs change on the falling edge, half a cycle before the DUT samples.
    task automatic applyStimulus(input logic rst, input logic en, input logic rv,
                                 input logic [1:0] rs, input logic pv,
                                 input logic [31:0] pd, input logic [3:0] pr);
        @(negedge clk);
        arst       = rst;
        cke        = en;
        reqValid   = rv;
        reqSel     = rs;
        rspValidIn = pv;
        rspDataIn  = pd;
        rspReadyIn = pr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
    endtask

    // Per-cycle comparison against the queue model, then the model advances
    // to the state the DUT will hold after the next rising edge.
    always begin : compareProc
        bit        empty;
        int        h;
        bit        expRspReady;
        bit        expReqReady;
        bit        doPush;
        bit        doPop;
        logic [3:0] expSel;
        logic [3:0] expValid;
        @(negedge clk);
        #2;
        if (arst) begin
            mq.delete();
            mErr = 1'b0;
        end
        empty       = (mq.size() == 0);
        h           = empty ? 0 : mq[0];
        expSel      = empty ? 4'b0 : 4'(1 << h);
        expValid    = (empty || !rspValidIn) ? 4'b0 : 4'(1 << h);
        expRspReady = !empty && rspReadyIn[h];
        expReqReady = (mq.size() != DEPTH);
        checkOutput("model_req_ready", 128'(reqReady), 128'(expReqReady));
        checkOutput("model_rsp_ready", 128'(rspReadyOut), 128'(expRspReady));
        checkOutput("model_rsp_valid", 128'(rspValidOut), 128'(expValid));
        checkOutput("model_rsp_sel", 128'(rspSel), 128'(expSel));
        checkOutput("model_rsp_data", rspDataOut, {4{rspDataIn}});
        checkOutput("model_outstanding", 128'(outstanding), 128'(mq.size()));
        checkOutput("model_err", 128'(err), 128'(mErr));
        if (!arst && cke) begin
            doPush = reqValid && expReqReady;
            doPop  = rspValidIn && expRspReady;
            if (rspValidIn && empty) mErr = 1'b1;
            if (doPop) void'(mq.pop_front());
            if (doPush) mq.push_back(int'(reqSel));
        end
    end

    initial begin
        arst = 1'b1; cke = 1'b1; reqValid = 1'b0; reqSel = 2'd0;
        rspValidIn = 1'b0; rspDataIn = 32'h0; rspReadyIn = 4'h0;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
        #3;
        checkOutput("rst_req_ready", 128'(reqReady), 128'(1));
        checkOutput("rst_rsp_ready", 128'(rspReadyOut), 128'(0));
        checkOutput("rst_rsp_valid", 128'(rspValidOut), 128'(0));
        checkOutput("rst_rsp_sel", 128'(rspSel), 128'(0));
        checkOutput("rst_outstanding", 128'(outstanding), 128'(0));
        checkOutput("rst_err", 128'(err), 128'(0));
        idle();

        // Single push of tag 2 then its response.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hA5A5A5A5, 4'b0100);
        #3;
        checkOutput("t1_valid", 128'(rspValidOut), 128'(4'b0100));
        checkOutput("t1_ready", 128'(rspReadyOut), 128'(1));
        checkOutput("t1_outst", 128'(outstanding), 128'(1));
        checkOutput("t1_data", 128'(rspDataOut[64 +: 32]), 128'(32'hA5A5A5A5));
        idle();
        #3;
        checkOutput("t1_outst_after", 128'(outstanding), 128'(0));

        // Three back-to-back pushes, responses in order.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h11111111, 4'hF);
        #3;
        checkOutput("t2_valid0", 128'(rspValidOut), 128'(4'b1000));
        checkOutput("t2_data0", 128'(rspDataOut[96 +: 32]), 128'(32'h11111111));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h22222222, 4'hF);
        #3;
        checkOutput("t2_valid1", 128'(rspValidOut), 128'(4'b0001));
        checkOutput("t2_data1", 128'(rspDataOut[0 +: 32]), 128'(32'h22222222));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h33333333, 4'hF);
        #3;
        checkOutput("t2_valid2", 128'(rspValidOut), 128'(4'b0010));
        checkOutput("t2_data2", 128'(rspDataOut[32 +: 32]), 128'(32'h33333333));

        // Fill to DEPTH, then push plus pop in the same cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'(i), 1'b0, 32'h0, 4'h0);
        end
        idle();
        #3;
        checkOutput("t3_full_ready", 128'(reqReady), 128'(0));
        checkOutput("t3_full_outst", 128'(outstanding), 128'(4));
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'hCAFE0000, 4'hF);
        #3;
        checkOutput("t3_pop_ready", 128'(rspReadyOut), 128'(1));
        idle();
        #3;
        checkOutput("t3_outst_after", 128'(outstanding), 128'(3));
        checkOutput("t3_ready_after", 128'(reqReady), 128'(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'(i), 4'hF);
        end

        // Response on an empty FIFO sets the sticky error.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hDEAD, 4'hF);
        #3;
        checkOutput("t4_empty_ready", 128'(rspReadyOut), 128'(0));
        idle();
        #3;
        checkOutput("t4_err", 128'(err), 128'(1));
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h1234, 4'hF);
        idle();
        #3;
        checkOutput("t4_err_sticky", 128'(err), 128'(1));

        // Backpressure on the head requester for three cycles.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hBEEF0001, 4'b1101);
            #3;
            checkOutput("t5_stall_ready", 128'(rspReadyOut), 128'(0));
            checkOutput("t5_stall_outst", 128'(outstanding), 128'(1));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hBEEF0001, 4'hF);
        #3;
        checkOutput("t5_release_ready", 128'(rspReadyOut), 128'(1));
        idle();
        #3;
        checkOutput("t5_outst_after", 128'(outstanding), 128'(0));

        // Reset mid-stream drops outstanding tags.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
        #3;
        checkOutput("t6_rst_outst", 128'(outstanding), 128'(0));
        checkOutput("t6_rst_sel", 128'(rspSel), 128'(0));
        checkOutput("t6_rst_err", 128'(err), 128'(0));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h5555, 4'hF);
        #3;
        checkOutput("t6_no_route", 128'(rspValidOut), 128'(0));
        idle();
        #3;
        checkOutput("t6_err", 128'(err), 128'(1));

        // Random traffic checked purely by the model.
        for (int c = 0; c < 800; c++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          $urandom(),
                          4'($urandom_range(0, 15)));
        end
        idle();
        idle();
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
